// File: rtl/conv2d_4x4_layer_pkg.sv
// conv2d_4x4_layer_pkg: shared fixed-point defaults, accumulator width and saturation limits.
package conv2d_4x4_layer_pkg;
  localparam int FRAC_BITS_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;
  function automatic int acc_width(input int dw);
    return 2 * dw + 4;
  endfunction
  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction
  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction
endpackage

// File: rtl/conv_window_4x4.sv
// conv_window_4x4: three line buffers plus a 4x4 window; row 0 is the oldest image row.
module conv_window_4x4 #(
  parameter int IMG_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  output logic [16*DATA_WIDTH-1:0]   taps_o,
  output logic                       win_valid_o
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);
  logic [CW-1:0] col_q, row_q, col_d, row_d;
  logic [DATA_WIDTH-1:0] win_q [4][4];
  logic [DATA_WIDTH-1:0] lb_q [3][IMG_WIDTH-1];
  logic win_valid_q;
  always_comb begin
    col_d = (col_q == LAST) ? '0 : col_q + CW'(1);
    row_d = (col_q != LAST) ? row_q : (row_q == LAST) ? '0 : row_q + CW'(1);
  end
  // Each line buffer is fed by the right column of the row below it, so its tail is one image row older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) win_q[r][c] <= '0;
      for (int l = 0; l < 3; l++)
        for (int k = 0; k < IMG_WIDTH - 1; k++) lb_q[l][k] <= '0;
    end else begin
      win_valid_q <= valid_i && row_q >= CW'(3) && col_q >= CW'(3);
      if (valid_i) begin
        col_q <= col_d;
        row_q <= row_d;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 3; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][3] <= (r == 3) ? data_i : lb_q[r][IMG_WIDTH-2];
        end
        for (int l = 0; l < 3; l++) begin
          lb_q[l][0] <= win_q[l+1][3];
          for (int k = 1; k < IMG_WIDTH - 1; k++) lb_q[l][k] <= lb_q[l][k-1];
        end
      end
    end
  end
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign taps_o[(4*r+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
    end
  end
  assign win_valid_o = win_valid_q;
endmodule

// File: rtl/conv2d_4x4_layer.sv
// conv2d_4x4_layer: streaming 4x4 valid convolution, Q-format MAC with bias, floor shift and saturation.
module conv2d_4x4_layer
  import conv2d_4x4_layer_pkg::*;
#(
  parameter int IMG_WIDTH  = 16,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic signed [DATA_WIDTH-1:0] w0,
  input  logic signed [DATA_WIDTH-1:0] w1,
  input  logic signed [DATA_WIDTH-1:0] w2,
  input  logic signed [DATA_WIDTH-1:0] w3,
  input  logic signed [DATA_WIDTH-1:0] w4,
  input  logic signed [DATA_WIDTH-1:0] w5,
  input  logic signed [DATA_WIDTH-1:0] w6,
  input  logic signed [DATA_WIDTH-1:0] w7,
  input  logic signed [DATA_WIDTH-1:0] w8,
  input  logic signed [DATA_WIDTH-1:0] w9,
  input  logic signed [DATA_WIDTH-1:0] w10,
  input  logic signed [DATA_WIDTH-1:0] w11,
  input  logic signed [DATA_WIDTH-1:0] w12,
  input  logic signed [DATA_WIDTH-1:0] w13,
  input  logic signed [DATA_WIDTH-1:0] w14,
  input  logic signed [DATA_WIDTH-1:0] w15,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = acc_width(DATA_WIDTH);
  localparam logic signed [AW-1:0] SMAX = AW'(sat_max(DATA_WIDTH));
  localparam logic signed [AW-1:0] SMIN = AW'(sat_min(DATA_WIDTH));
  logic [16*DW-1:0] taps;
  logic win_valid, v1_q;
  logic signed [DW-1:0] w_arr [16];
  logic signed [PW-1:0] prod_d [16];
  logic signed [PW-1:0] prod_q [16];
  logic signed [AW-1:0] acc, sh;
  logic signed [DW-1:0] res_d;
  conv_window_4x4 #(.IMG_WIDTH(IMG_WIDTH), .DATA_WIDTH(DW)) u_win (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_in),
    .data_i      (data_in),
    .taps_o      (taps),
    .win_valid_o (win_valid)
  );
  always_comb begin
    w_arr = '{w0, w1, w2, w3, w4, w5, w6, w7, w8, w9, w10, w11, w12, w13, w14, w15};
    for (int i = 0; i < 16; i++)
      prod_d[i] = PW'($signed(taps[i*DW +: DW])) * PW'(w_arr[i]);
  end
  // Bias is aligned to the product scale before the single floor shift.
  always_comb begin
    acc = AW'(bias) <<< FRAC_BITS;
    for (int i = 0; i < 16; i++) acc = acc + AW'(prod_q[i]);
    sh    = acc >>> FRAC_BITS;
    res_d = (sh > SMAX) ? DW'(SMAX) : (sh < SMIN) ? DW'(SMIN) : sh[DW-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      for (int i = 0; i < 16; i++) prod_q[i] <= '0;
    end else begin
      v1_q      <= win_valid;
      prod_q    <= prod_d;
      valid_out <= v1_q;
      data_out  <= res_d;
    end
  end
endmodule

// File: tb/tb_conv2d_4x4_layer.sv
// tb_conv2d_4x4_layer: directed frames with hand-derived expected outputs and latency checks.
module tb_conv2d_4x4_layer;
  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, valid_out;
  logic signed [15:0] data_in = '0, bias = '0, data_out;
  logic signed [15:0] w [16];
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic signed [15:0] got_q[$];
  int got_t[$];
  int px_t[$];

  conv2d_4x4_layer dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]),
    .w4(w[4]), .w5(w[5]), .w6(w[6]), .w7(w[7]),
    .w8(w[8]), .w9(w[9]), .w10(w[10]), .w11(w[11]),
    .w12(w[12]), .w13(w[13]), .w14(w[14]), .w15(w[15]),
    .bias(bias), .valid_out(valid_out), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (valid_out === 1'b1) begin
      got_q.push_back(data_out);
      got_t.push_back(cyc);
    end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int all, input int first, input int b);
    for (int i = 0; i < 16; i++) w[i] = 16'(all);
    w[0] = 16'(first);
    bias = 16'(b);
  endtask

  task automatic send(input int npix, input int px, input bit ramp, input bit idle);
    for (int i = 0; i < npix; i++) begin
      tick();
      valid_in = 1'b1;
      data_in  = ramp ? 16'(i) : 16'(px);
      if ((i / 16) >= 3 && (i % 16) >= 3) px_t.push_back(cyc);
      if (idle) begin
        tick();
        valid_in = 1'b0;
      end
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic clear_q();
    got_q.delete();
    got_t.delete();
    px_t.delete();
  endtask

  task automatic check(input string tag, input bit ramp, input int k, input bit lat);
    repeat (6) tick();
    chk({tag, " count"}, got_q.size(), 169);
    for (int i = 0; i < got_q.size() && i < 169; i++) begin
      chk({tag, " value"}, int'(got_q[i]), ramp ? (i / 13) * 16 + i % 13 : k);
      if (lat) chk({tag, " latency"}, got_t[i], px_t[i] + 3);
    end
    clear_q();
  endtask

  initial begin
    set_w(0, 0, 0);
    #12;
    chk("reset valid_out", int'(valid_out), 0);
    chk("reset data_out", int'(data_out), 0);
    tick();
    rst_n = 1'b1;
    set_w('h0100, 'h0100, 0);
    send(256, 'h0100, 1'b0, 1'b0);
    check("ones", 1'b0, 4096, 1'b1);
    send(256, 'hFF00, 1'b0, 1'b0);
    check("neg ones", 1'b0, -4096, 1'b0);
    send(256, 'h7F00, 1'b0, 1'b0);
    check("sat high", 1'b0, 32767, 1'b0);
    send(256, 'h8100, 1'b0, 1'b0);
    check("sat low", 1'b0, -32768, 1'b0);
    set_w(0, 0, 'h0180);
    send(256, 'h1234, 1'b0, 1'b0);
    check("bias only", 1'b0, 384, 1'b0);
    set_w(0, 'h0100, 0);
    send(256, 0, 1'b1, 1'b0);
    check("ramp", 1'b1, 0, 1'b1);
    send(256, 0, 1'b1, 1'b1);
    check("ramp idle", 1'b1, 0, 1'b1);
    send(50, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid reset valid_out", int'(valid_out), 0);
    chk("mid reset data_out", int'(data_out), 0);
    tick();
    tick();
    chk("mid reset held valid_out", int'(valid_out), 0);
    rst_n = 1'b1;
    clear_q();
    send(256, 0, 1'b1, 1'b0);
    check("after reset", 1'b1, 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv2d_4x4_layer.md
CONV2D_4X4_LAYER -- requirements
Module: conv2d_4x4_layer

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 16: square input image side in pixels, at least 4.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16: width of pixel, weight, bias and output words, all signed Q8.8.
REQ-003 The block SHALL have parameter FRAC_BITS, default 8: number of fractional bits in the fixed-point format.
REQ-004 The block SHALL have input clk (1 bit): the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have input rst_n (1 bit): reset, asynchronous and active-low.
REQ-006 The block SHALL have input valid_in (1 bit): data_in carries a pixel this cycle.
REQ-007 The block SHALL have input data_in (DATA_WIDTH, signed): pixel stream in raster order, row 0 first, left to right.
REQ-008 The block SHALL have inputs w0..w15 (DATA_WIDTH each, signed): kernel weights, row-major; w(4r+c) multiplies window row r, column c, where row 0 is the oldest image row and column 0 the leftmost.
REQ-009 The block SHALL have input bias (DATA_WIDTH, signed): bias in Q8.8.
REQ-010 The block SHALL have output valid_out (1 bit): data_out holds a result this cycle.
REQ-011 The block SHALL have output data_out (DATA_WIDTH, signed): convolution result in Q8.8.

Function
REQ-012 The block SHALL compute stride-1, no-padding ("valid") 2-D convolution, giving (IMG_WIDTH-3)x(IMG_WIDTH-3) outputs per frame (169 for IMG_WIDTH=16), emitted in raster order.
REQ-013 A pixel SHALL be accepted only in cycles with valid_in=1; idle cycles SHALL NOT advance the column/row counters or the line buffers.
REQ-014 Three line buffers of IMG_WIDTH-1 entries each, plus a 4x4 window register, SHALL hold the current window.
REQ-015 A window SHALL be valid when the accepted pixel is at row>=3 and column>=3 (0-based); other positions SHALL produce no output.
REQ-016 Arithmetic SHALL be: 16 full-precision signed products of 2*DATA_WIDTH bits, summed in an accumulator of at least 2*DATA_WIDTH+4 bits, plus bias sign-extended and shifted left by FRAC_BITS.
REQ-017 The accumulator SHALL then be shifted arithmetically right by FRAC_BITS (truncation toward minus infinity).
REQ-018 The shifted result SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. [-32768, 32767].
REQ-019 Latency SHALL be fixed: valid_out SHALL be high exactly 3 cycles after the cycle in which the window's bottom-right pixel was presented with valid_in=1.
REQ-020 valid_out SHALL be high for exactly one cycle per result.
REQ-021 The pipeline SHALL advance every cycle regardless of valid_in; there is no backpressure.
REQ-022 After IMG_WIDTH*IMG_WIDTH accepted pixels, the row and column counters SHALL wrap to 0 and the next frame SHALL start with no idle cycle required.
REQ-023 Weights and bias SHALL be treated as quasi-static; a change while a window is in flight gives undefined results for that window only.

Reset
REQ-024 While rst_n=0, valid_out, data_out, the counters, the pipeline valid bits, the window registers and the line buffers SHALL all be 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the first pixel accepted after release SHALL be treated as row 0, column 0.

Structure
REQ-026 A shared package SHALL hold FRAC_BITS, the accumulator width and the saturation limits.
REQ-027 The line buffers and 4x4 window register SHALL be one sub-module, conv_window_4x4, which outputs 16 taps and a window-valid flag.
REQ-028 The multiply, adder tree, bias add, shift and saturation SHALL live in conv2d_4x4_layer.

Verification
REQ-029 All pixels 0x0100, all weights 0x0100, bias 0 -> 169 outputs, each 4096; then all pixels 0xFF00 -> each output -4096.
REQ-030 w0=0x0100, other weights 0, bias 0, pixel raw value equal to raster index -> output (r,c) equals r*16+c (first 0, last 204).
REQ-031 All pixels 0x7F00, all weights 0x0100 -> every output saturates to 32767; all pixels 0x8100 -> every output -32768.
REQ-032 All weights 0, bias 0x0180 -> 169 outputs, each 384.
REQ-033 Same stimulus as REQ-030 with one idle cycle after every pixel -> identical 169-value sequence, each output 3 cycles after its bottom-right pixel.
REQ-034 rst_n pulsed low after 50 pixels, then a full new frame -> valid_out low during reset, then exactly 169 correct outputs.
